// File: rtl/bridge_resp_id_tracker_pkg.sv
// -----------------------------------------------------------------------------
// bridge_resp_pkg
// Shared constants, types and helpers for the XBAR bridge response ID tracker.
//   DEFAULT_ID_WIDTH      : one-hot master ID width (number of masters)
//   DEFAULT_DATA_WIDTH    : response read-data width
//   DEFAULT_N_OUTSTANDING : depth of the outstanding-ID FIFO
//   ptrWidth()            : FIFO pointer width for a given depth
//   id_entry_t            : one FIFO entry (a one-hot master ID) at default width
// No ports (package).
// -----------------------------------------------------------------------------
package bridge_resp_pkg;

    localparam int DEFAULT_ID_WIDTH      = 20;
    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_N_OUTSTANDING = 4;

    // A FIFO entry is just the one-hot ID of the master that owns the
    // outstanding transaction; parameterised users declare the same shape
    // with their own ID_WIDTH.
    typedef logic [DEFAULT_ID_WIDTH-1:0] id_entry_t;

    // Pointer width for a power-of-two depth; never below one bit so that a
    // degenerate depth still elaborates.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bridge_resp_id_tracker_if.sv
// -----------------------------------------------------------------------------
// bridge_resp_id_tracker_if
// Bundles the request/grant handshake and response bus around the tracker.
// Signal names are written from the tracker's point of view (_i into it,
// _o out of it).
//   slave modport  : the tracker itself
//   master modport : whoever drives the arbiter/slave side (e.g. a bench)
// Signals:
//   data_req_i/data_ID_i/data_gnt_o  : arbiter request, one-hot ID, grant back
//   data_req_o/data_gnt_i            : request to slave, grant from slave
//   data_r_valid_i/data_r_rdata_i    : slave response
//   data_r_valid_o/data_ID_o/data_r_rdata_o : registered response to decoder
//   full_o, err_o                    : FIFO full, sticky protocol error
// -----------------------------------------------------------------------------
interface bridge_resp_id_tracker_if
    import bridge_resp_pkg::*;
#(
    parameter int ID_WIDTH   = DEFAULT_ID_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  data_req_i;
    logic [ID_WIDTH-1:0]   data_ID_i;
    logic                  data_gnt_o;
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic                  data_r_valid_i;
    logic [DATA_WIDTH-1:0] data_r_rdata_i;
    logic                  data_r_valid_o;
    logic [ID_WIDTH-1:0]   data_ID_o;
    logic [DATA_WIDTH-1:0] data_r_rdata_o;
    logic                  full_o;
    logic                  err_o;

    modport slave (
        input  data_req_i, data_ID_i, data_gnt_i, data_r_valid_i, data_r_rdata_i,
        output data_gnt_o, data_req_o, data_r_valid_o, data_ID_o, data_r_rdata_o,
               full_o, err_o
    );

    modport master (
        output data_req_i, data_ID_i, data_gnt_i, data_r_valid_i, data_r_rdata_i,
        input  data_gnt_o, data_req_o, data_r_valid_o, data_ID_o, data_r_rdata_o,
               full_o, err_o
    );
endinterface

// File: rtl/bridge_resp_id_tracker_fifo.sv
// -----------------------------------------------------------------------------
// bridge_id_fifo
// Plain synchronous FIFO holding the IDs of outstanding transactions.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i at the tail (ignored when full)
//   wdata_i   : entry to write
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : current head entry (combinational)
//   full_o    : registered full flag
//   empty_o   : registered empty flag
// -----------------------------------------------------------------------------
module bridge_id_fifo
    import bridge_resp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ID_WIDTH,
    parameter int DEPTH = DEFAULT_N_OUTSTANDING
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = ptrWidth(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    // Flags come straight from the registered count, so nothing downstream
    // sees a combinational path from this cycle's push/pop.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign rdata_o = mem_q[rdPtr_q];

    // Next-state for pointers and occupancy. Pointers are exactly log2(DEPTH)
    // bits so they wrap on their own; count only moves when exactly one of
    // push/pop happens.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards every stored entry by simply
    // rewinding the pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: an entry is only ever read after it was
    // written, because the pointers/count guard every access.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bridge_resp_id_tracker.sv
// -----------------------------------------------------------------------------
// bridge_resp_id_tracker
// In-order outstanding-transaction tracker for the XBAR bridge response path.
// Records the one-hot master ID of every granted request, pops the oldest ID
// on every slave response and presents a registered response carrying that
// ID to the response address decoder. New requests are throttled while the
// tracking FIFO is full.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : bridge_resp_id_tracker_if.slave (handshake, response bus, full_o,
//          err_o)
// Optional build macro BRIDGE_RESP_TRACKER_CHECK_EN: when defined, err_o is a
// sticky flag raised by a response while nothing is outstanding or by a push
// with a non-one-hot ID; when undefined err_o is tied low.
// -----------------------------------------------------------------------------
module bridge_resp_id_tracker
    import bridge_resp_pkg::*;
#(
    parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int N_OUTSTANDING = DEFAULT_N_OUTSTANDING
) (
    input logic                     clk,
    input logic                     rst,
    bridge_resp_id_tracker_if.slave bus
);
    logic                  fullFlag;
    logic                  emptyFlag;
    logic                  doPush;
    logic                  doPop;
    logic [ID_WIDTH-1:0]   headId;
    logic                  rValid_q, rValid_d;
    logic [ID_WIDTH-1:0]   rId_q, rId_d;
    logic [DATA_WIDTH-1:0] rData_q, rData_d;

    // Request gating uses only the registered full flag: a response popping
    // in the same cycle does not free a slot until the next cycle, which
    // keeps r_valid out of the grant timing path.
    assign bus.data_req_o = bus.data_req_i & ~fullFlag;
    assign bus.data_gnt_o = bus.data_gnt_i & ~fullFlag;
    assign doPush         = bus.data_req_o & bus.data_gnt_i;
    // A response with nothing outstanding is dropped rather than popped.
    assign doPop          = bus.data_r_valid_i & ~emptyFlag;
    assign bus.full_o     = fullFlag;

    bridge_id_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (N_OUTSTANDING)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (doPush),
        .wdata_i (bus.data_ID_i),
        .pop_i   (doPop),
        .rdata_o (headId),
        .full_o  (fullFlag),
        .empty_o (emptyFlag)
    );

    // Response stage: a pop this cycle becomes a one-cycle valid with the
    // popped ID next cycle. The ID returns to zero when idle so the decoder
    // never sees a stale owner; the data simply holds.
    always_comb begin
        rValid_d = doPop;
        rId_d    = '0;
        rData_d  = rData_q;
        if (doPop) begin
            rId_d   = headId;
            rData_d = bus.data_r_rdata_i;
        end
    end

    // Response stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rValid_q <= 1'b0;
            rId_q    <= '0;
            rData_q  <= '0;
        end else begin
            rValid_q <= rValid_d;
            rId_q    <= rId_d;
            rData_q  <= rData_d;
        end
    end

    assign bus.data_r_valid_o = rValid_q;
    assign bus.data_ID_o      = rId_q;
    assign bus.data_r_rdata_o = rData_q;

`ifdef BRIDGE_RESP_TRACKER_CHECK_EN
    logic err_q, err_d;

    // Protocol checks: an orphan response or a malformed ID latches the
    // error until reset. The offending traffic is still handled normally.
    always_comb begin
        err_d = err_q;
        if ((bus.data_r_valid_i && emptyFlag) ||
            (doPush && !$onehot(bus.data_ID_i))) begin
            err_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_resp_id_tracker.sv
// -----------------------------------------------------------------------------
// tb_bridge_resp_id_tracker
// Self-checking bench for bridge_resp_id_tracker. A queue-based reference
// model tracks outstanding IDs; directed scenarios are followed by random
// traffic with occasional resets and malformed IDs.
// -----------------------------------------------------------------------------
module tb_bridge_resp_id_tracker;
    localparam int IDW   = 20;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    bridge_resp_id_tracker_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

    bridge_resp_id_tracker #(
        .ID_WIDTH      (IDW),
        .DATA_WIDTH    (DW),
        .N_OUTSTANDING (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model state: outstanding IDs in arrival order plus the
    // expected registered response and sticky error.
    logic [IDW-1:0] modelQ [$];
    logic           expValid;
    logic [IDW-1:0] expId;
    logic [DW-1:0]  expRdata;
    logic           expErr;
    bit             modelValid = 0;
    bit             checkEn;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [IDW-1:0] randOnehot();
        logic [IDW-1:0] one;
        one = 1;
        return one << $urandom_range(0, IDW - 1);
    endfunction

    // Drive one cycle of inputs (called just after a falling edge), check the
    // combinational gating, advance the model across the rising edge, then
    // check the registered outputs.
    task automatic applyStimulus(input logic rstV, input logic reqV,
                                 input logic [IDW-1:0] idV, input logic gntV,
                                 input logic rvV, input logic [DW-1:0] rdV);
        bit fullNow;
        bit doPush;
        bit doPop;
        rst                = rstV;
        bus.data_req_i     = reqV;
        bus.data_ID_i      = idV;
        bus.data_gnt_i     = gntV;
        bus.data_r_valid_i = rvV;
        bus.data_r_rdata_i = rdV;
        #1;
        fullNow = (modelQ.size() == DEPTH);
        if (modelValid) begin
            checkOutput("data_req_o", 64'(bus.data_req_o), 64'(reqV & ~fullNow));
            checkOutput("data_gnt_o", 64'(bus.data_gnt_o), 64'(gntV & ~fullNow));
        end
        @(posedge clk);
        if (rstV) begin
            modelQ.delete();
            expValid   = 1'b0;
            expId      = '0;
            expRdata   = '0;
            expErr     = 1'b0;
            modelValid = 1;
        end else begin
            doPop  = rvV && (modelQ.size() > 0);
            doPush = reqV && gntV && !fullNow;
            if (checkEn && ((rvV && modelQ.size() == 0) || (doPush && !$onehot(idV))))
                expErr = 1'b1;
            if (doPop) begin
                expValid = 1'b1;
                expId    = modelQ.pop_front();
                expRdata = rdV;
            end else begin
                expValid = 1'b0;
                expId    = '0;
            end
            if (doPush) modelQ.push_back(idV);
        end
        #1;
        if (modelValid) begin
            checkOutput("data_r_valid_o", 64'(bus.data_r_valid_o), 64'(expValid));
            checkOutput("data_ID_o", 64'(bus.data_ID_o), 64'(expId));
            checkOutput("data_r_rdata_o", 64'(bus.data_r_rdata_o), 64'(expRdata));
            checkOutput("full_o", 64'(bus.full_o), 64'(modelQ.size() == DEPTH));
            checkOutput("err_o", 64'(bus.err_o), 64'(expErr));
            checkOutput("count", 64'(dut.u_fifo.count_q), 64'(modelQ.size()));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, '0, 0, 0, $urandom);
    endtask

    task automatic pushId(input logic [IDW-1:0] id);
        applyStimulus(0, 1, id, 1, 0, $urandom);
    endtask

    task automatic respond(input logic [DW-1:0] rd);
        applyStimulus(0, 0, '0, 0, 1, rd);
    endtask

    // Directed scenarios, then randomized traffic.
    initial begin
        logic [IDW-1:0] badId;
`ifdef BRIDGE_RESP_TRACKER_CHECK_EN
        checkEn = 1;
`else
        checkEn = 0;
`endif
        rst = 1'b1;
        bus.data_req_i = 0; bus.data_ID_i = '0; bus.data_gnt_i = 0;
        bus.data_r_valid_i = 0; bus.data_r_rdata_i = '0;
        @(negedge clk);
        applyStimulus(1, 0, '0, 0, 0, '0);
        applyStimulus(1, 0, '0, 0, 0, '0);

        // Single transaction: push at t0, response at t3.
        pushId(20'h00004);
        idle();
        idle();
        respond(32'hCAFE0001);
        checkOutput("single_id", 64'(bus.data_ID_o), 64'h4);
        checkOutput("single_rdata", 64'(bus.data_r_rdata_o), 64'hCAFE0001);
        idle();

        // Ordering across three outstanding transactions.
        pushId(20'h00001);
        pushId(20'h00002);
        pushId(20'h00008);
        respond(32'h11111111);
        respond(32'h22222222);
        respond(32'h33333333);
        idle();

        // Fill, stay blocked, free one slot, refill (write pointer wraps).
        for (int i = 0; i < DEPTH; i++) pushId(randOnehot());
        pushId(randOnehot());
        pushId(randOnehot());
        applyStimulus(0, 1, randOnehot(), 1, 1, $urandom);
        pushId(20'h80000);
        for (int i = 0; i < DEPTH + 1; i++) respond($urandom);

        // Simultaneous push and pop holding count at two.
        pushId(randOnehot());
        pushId(randOnehot());
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, randOnehot(), 1, 1, $urandom);
        respond($urandom);
        respond($urandom);
        idle();

        // Reset with three outstanding, then an orphan response.
        for (int i = 0; i < 3; i++) pushId(randOnehot());
        applyStimulus(1, 0, '0, 0, 0, '0);
        respond(32'hDEAD0000);
        idle();

        // Protocol-error stimulus: orphan response, then a two-hot ID.
        applyStimulus(1, 0, '0, 0, 0, '0);
        respond(32'h0BAD0001);
        idle();
        applyStimulus(1, 0, '0, 0, 0, '0);
        pushId(20'h00003);
        idle();
        respond($urandom);
        applyStimulus(1, 0, '0, 0, 0, '0);

        // Random traffic with occasional malformed IDs and resets.
        for (int i = 0; i < 600; i++) begin
            badId = ($urandom_range(0, 29) == 0) ? IDW'($urandom) : randOnehot();
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 99) < 60), badId,
                          ($urandom_range(0, 99) < 70),
                          ($urandom_range(0, 99) < 45), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
